// File: rtl/axil_rd_timeout.sv
// AXI-lite read timeout stage: forwards one read at a time toward the CDC and
// answers the requester with SLVERR if the far side stays silent for TIMEOUT cycles.
module axil_rd_timeout #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 1024,
    parameter logic [31:0] ERR_DATA   = 32'hDEADBEEF
) (
    input  logic                  s_clk,
    input  logic                  s_rst,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready,
    output logic [15:0]           timeout_count,
    output logic                  busy
);

    localparam int unsigned           CNT_W       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]      CNT_LAST    = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE     = CNT_W'(1);
    localparam logic [DATA_WIDTH-1:0] ERR_RDATA   = DATA_WIDTH'(ERR_DATA);
    localparam logic [1:0]            RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        ERESP = 3'd4,
        DRAIN = 3'd5
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t                  state_r, state_n;
    logic [ADDR_WIDTH-1:0]   addr_r, addr_n;
    logic [2:0]              prot_r, prot_n;
    logic                    arvalid_r, arvalid_n;
    logic [DATA_WIDTH-1:0]   rdata_r, rdata_n;
    logic [1:0]              rresp_r, rresp_n;
    logic                    rvalid_r, rvalid_n;
    logic [CNT_W-1:0]        cnt_r, cnt_n;
    logic                    late_done_r, late_done_n;
    logic [15:0]             tcount_r, tcount_n;

    logic                    ar_hs_s;
    logic                    m_ar_hs_s;
    logic                    m_rready_s;
    logic                    m_r_hs_s;

    // After a timeout the late response is only accepted once the address has gone out.
    assign m_rready_s = (state_r == WAIT) ||
                        (((state_r == ERESP) || (state_r == DRAIN)) && !arvalid_r && !late_done_r);
    assign ar_hs_s    = s_axil_arvalid && (state_r == IDLE);
    assign m_ar_hs_s  = arvalid_r && m_axil_arready;
    assign m_r_hs_s   = m_axil_rvalid && m_rready_s;

    assign s_axil_arready = (state_r == IDLE);
    assign busy           = (state_r != IDLE);
    assign m_axil_rready  = m_rready_s;
    assign m_axil_araddr  = addr_r;
    assign m_axil_arprot  = prot_r;
    assign m_axil_arvalid = arvalid_r;
    assign s_axil_rdata   = rdata_r;
    assign s_axil_rresp   = rresp_r;
    assign s_axil_rvalid  = rvalid_r;
    assign timeout_count  = tcount_r;

    // Next-state and next-register values for the whole transaction FSM.
    always_comb begin
        state_n     = state_r;
        addr_n      = addr_r;
        prot_n      = prot_r;
        rdata_n     = rdata_r;
        rresp_n     = rresp_r;
        rvalid_n    = rvalid_r;
        cnt_n       = cnt_r;
        late_done_n = late_done_r;
        tcount_n    = tcount_r;

        // The downstream address is never withdrawn, whatever the FSM is doing.
        if (m_ar_hs_s) begin
            arvalid_n = 1'b0;
        end else begin
            arvalid_n = arvalid_r;
        end

        case (state_r)
            IDLE: begin
                if (ar_hs_s) begin
                    addr_n      = s_axil_araddr;
                    prot_n      = s_axil_arprot;
                    arvalid_n   = 1'b1;
                    cnt_n       = '0;
                    late_done_n = 1'b0;
                    state_n     = ADDR;
                end else begin
                    state_n = IDLE;
                end
            end
            ADDR: begin
                if (cnt_r == CNT_LAST) begin
                    state_n  = ERESP;
                    rvalid_n = 1'b1;
                    rdata_n  = ERR_RDATA;
                    rresp_n  = RESP_SLVERR;
                    tcount_n = sat_inc16(tcount_r);
                end else begin
                    cnt_n   = cnt_r + CNT_ONE;
                    state_n = m_ar_hs_s ? WAIT : ADDR;
                end
            end
            WAIT: begin
                // A response in the expiry cycle beats the timeout.
                if (m_axil_rvalid) begin
                    rdata_n  = m_axil_rdata;
                    rresp_n  = m_axil_rresp;
                    rvalid_n = 1'b1;
                    state_n  = RESP;
                end else if (cnt_r == CNT_LAST) begin
                    state_n  = ERESP;
                    rvalid_n = 1'b1;
                    rdata_n  = ERR_RDATA;
                    rresp_n  = RESP_SLVERR;
                    tcount_n = sat_inc16(tcount_r);
                end else begin
                    cnt_n = cnt_r + CNT_ONE;
                end
            end
            RESP: begin
                if (s_axil_rready) begin
                    rvalid_n = 1'b0;
                    state_n  = IDLE;
                end else begin
                    state_n = RESP;
                end
            end
            ERESP: begin
                if (m_r_hs_s) begin
                    late_done_n = 1'b1;
                end else begin
                    late_done_n = late_done_r;
                end
                if (s_axil_rready) begin
                    rvalid_n = 1'b0;
                    state_n  = (late_done_r || m_r_hs_s) ? IDLE : DRAIN;
                end else begin
                    state_n = ERESP;
                end
            end
            DRAIN: begin
                if (m_r_hs_s) begin
                    late_done_n = 1'b1;
                    state_n     = IDLE;
                end else begin
                    state_n = DRAIN;
                end
            end
            default: begin
                state_n  = IDLE;
                rvalid_n = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            state_r     <= IDLE;
            addr_r      <= '0;
            prot_r      <= 3'b000;
            arvalid_r   <= 1'b0;
            rdata_r     <= '0;
            rresp_r     <= 2'b00;
            rvalid_r    <= 1'b0;
            cnt_r       <= '0;
            late_done_r <= 1'b0;
            tcount_r    <= 16'h0000;
        end else begin
            state_r     <= state_n;
            addr_r      <= addr_n;
            prot_r      <= prot_n;
            arvalid_r   <= arvalid_n;
            rdata_r     <= rdata_n;
            rresp_r     <= rresp_n;
            rvalid_r    <= rvalid_n;
            cnt_r       <= cnt_n;
            late_done_r <= late_done_n;
            tcount_r    <= tcount_n;
        end
    end

endmodule

// File: tb/tb_axil_rd_timeout.sv
// Scoreboard-driven bench for axil_rd_timeout with TIMEOUT=16: normal reads,
// timeouts in ADDR and WAIT, the expiry tie, backpressure and async reset.
module tb_axil_rd_timeout;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 16;

    logic          s_clk = 1'b0;
    logic          s_rst;
    logic [AW-1:0] s_axil_araddr;
    logic [2:0]    s_axil_arprot;
    logic          s_axil_arvalid;
    logic          s_axil_arready;
    logic [DW-1:0] s_axil_rdata;
    logic [1:0]    s_axil_rresp;
    logic          s_axil_rvalid;
    logic          s_axil_rready;
    logic [AW-1:0] m_axil_araddr;
    logic [2:0]    m_axil_arprot;
    logic          m_axil_arvalid;
    logic          m_axil_arready;
    logic [DW-1:0] m_axil_rdata;
    logic [1:0]    m_axil_rresp;
    logic          m_axil_rvalid;
    logic          m_axil_rready;
    logic [15:0]   timeout_count;
    logic          busy;

    axil_rd_timeout #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO), .ERR_DATA(32'hDEADBEEF)
    ) dut (
        .s_clk(s_clk), .s_rst(s_rst),
        .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
        .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
        .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
        .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
        .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
        .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
        .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
        .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready),
        .timeout_count(timeout_count), .busy(busy)
    );

    always #5 s_clk = ~s_clk;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] exp_tcount = 16'd0;

    task automatic tick();
        @(posedge s_clk);
        #1;
    endtask

    task automatic accept_ar(input logic [31:0] addr, input logic [2:0] prot);
        s_axil_araddr  = addr;
        s_axil_arprot  = prot;
        s_axil_arvalid = 1'b1;
        tick();
        s_axil_arvalid = 1'b0;
    endtask

    task automatic wait_rvalid(input int budget, output int cycles);
        cycles = 0;
        while (s_axil_rvalid !== 1'b1 && cycles < budget) begin
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        s_rst = 1'b1;
        s_axil_araddr = '0; s_axil_arprot = 3'b000; s_axil_arvalid = 1'b0;
        s_axil_rready = 1'b0; m_axil_arready = 1'b0; m_axil_rdata = '0;
        m_axil_rresp = 2'b00; m_axil_rvalid = 1'b0;
        tick(); tick();
        vectors++;
        if ({s_axil_arready, m_axil_rready, busy, s_axil_rvalid, m_axil_arvalid} !== 5'b10000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got arrdy/rrdy/busy/rvld/arvld=%b want 10000",
                     {s_axil_arready, m_axil_rready, busy, s_axil_rvalid, m_axil_arvalid});
        end
        vectors++;
        if ({timeout_count, s_axil_rdata, m_axil_araddr} !== 80'd0) begin
            miscompares++;
            $display("FAIL reset_regs: got tcount=%h rdata=%h araddr=%h want zeros",
                     timeout_count, s_axil_rdata, m_axil_araddr);
        end
        s_rst = 1'b0;
        tick();
        vectors++;
        if (s_axil_arready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release: got arready=%b want 1", s_axil_arready);
        end
    endtask

    task automatic test_normal();
        int cyc;
        accept_ar(32'h0000_1000, 3'b010);
        vectors++;
        if ({m_axil_arvalid, m_axil_araddr, m_axil_arprot} !== {1'b1, 32'h0000_1000, 3'b010}) begin
            miscompares++;
            $display("FAIL normal_fwd: got arvalid=%b addr=%h prot=%b want 1 00001000 010",
                     m_axil_arvalid, m_axil_araddr, m_axil_arprot);
        end
        tick();
        m_axil_arready = 1'b1; tick(); m_axil_arready = 1'b0;
        vectors++;
        if (m_axil_arvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL normal_arclr: got arvalid=%b want 0", m_axil_arvalid);
        end
        tick(); tick();
        m_axil_rvalid = 1'b1; m_axil_rdata = 32'h1234_5678; m_axil_rresp = 2'b00;
        sb.push_back({32'h1234_5678, 2'b00});
        tick();
        m_axil_rvalid = 1'b0;
        wait_rvalid(4, cyc);
        vectors++;
        if (cyc !== 0 || s_axil_rvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL normal_lat: got rvalid=%b after %0d cycles want 1 after 0", s_axil_rvalid, cyc);
        end
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL normal_sb: got a response, scoreboard empty");
        end else begin
            e = sb.pop_front();
            if ({s_axil_rdata, s_axil_rresp} !== {e.data, e.resp}) begin
                miscompares++;
                $display("FAIL normal_data: got %h/%b want %h/%b", s_axil_rdata, s_axil_rresp, e.data, e.resp);
            end
        end
        s_axil_rready = 1'b1; tick(); s_axil_rready = 1'b0;
        vectors++;
        if ({s_axil_rvalid, s_axil_arready, timeout_count} !== {1'b0, 1'b1, exp_tcount}) begin
            miscompares++;
            $display("FAIL normal_done: got rvalid=%b arready=%b tcount=%0d want 0 1 %0d",
                     s_axil_rvalid, s_axil_arready, timeout_count, exp_tcount);
        end
    endtask

    task automatic test_timeout_wait();
        int cyc;
        bit bad;
        accept_ar(32'h0000_2000, 3'b000);
        m_axil_arready = 1'b1; tick(); m_axil_arready = 1'b0;
        sb.push_back({32'hDEADBEEF, 2'b10});
        exp_tcount = exp_tcount + 16'd1;
        wait_rvalid(40, cyc);
        vectors++;
        if (s_axil_rvalid !== 1'b1 || cyc + 1 !== TO) begin
            miscompares++;
            $display("FAIL towait_lat: got rvalid=%b latency %0d want 1 latency %0d", s_axil_rvalid, cyc + 1, TO);
        end
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL towait_sb: got a response, scoreboard empty");
        end else begin
            e = sb.pop_front();
            if ({s_axil_rdata, s_axil_rresp, timeout_count} !== {e.data, e.resp, exp_tcount}) begin
                miscompares++;
                $display("FAIL towait_data: got %h/%b cnt %0d want %h/%b cnt %0d",
                         s_axil_rdata, s_axil_rresp, timeout_count, e.data, e.resp, exp_tcount);
            end
        end
        s_axil_rready = 1'b1; tick(); s_axil_rready = 1'b0;
        vectors++;
        if ({s_axil_rvalid, busy, s_axil_arready, m_axil_rready} !== 4'b0101) begin
            miscompares++;
            $display("FAIL towait_drain: got rvld/busy/arrdy/rrdy=%b want 0101",
                     {s_axil_rvalid, busy, s_axil_arready, m_axil_rready});
        end
        bad = 1'b0;
        for (int i = 0; i < 22; i++) begin
            tick();
            if (s_axil_arready !== 1'b0) bad = 1'b1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL towait_hold: got arready=1 before late response want 0");
        end
        m_axil_rvalid = 1'b1; m_axil_rdata = 32'h0BAD_F00D; m_axil_rresp = 2'b00;
        tick();
        m_axil_rvalid = 1'b0;
        tick();
        vectors++;
        if ({s_axil_arready, busy, s_axil_rvalid} !== 3'b100) begin
            miscompares++;
            $display("FAIL towait_late: got arrdy/busy/rvld=%b want 100", {s_axil_arready, busy, s_axil_rvalid});
        end
    endtask

    task automatic test_timeout_addr();
        int cyc;
        bit bad;
        accept_ar(32'h0000_3000, 3'b101);
        sb.push_back({32'hDEADBEEF, 2'b10});
        exp_tcount = exp_tcount + 16'd1;
        wait_rvalid(40, cyc);
        vectors++;
        if (s_axil_rvalid !== 1'b1 || cyc !== TO) begin
            miscompares++;
            $display("FAIL toaddr_lat: got rvalid=%b latency %0d want 1 latency %0d", s_axil_rvalid, cyc, TO);
        end
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL toaddr_sb: got a response, scoreboard empty");
        end else begin
            e = sb.pop_front();
            if ({s_axil_rdata, s_axil_rresp} !== {e.data, e.resp}) begin
                miscompares++;
                $display("FAIL toaddr_data: got %h/%b want %h/%b", s_axil_rdata, s_axil_rresp, e.data, e.resp);
            end
        end
        s_axil_rready = 1'b1; tick(); s_axil_rready = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (m_axil_arvalid !== 1'b1 || m_axil_araddr !== 32'h0000_3000 || m_axil_arprot !== 3'b101 ||
                m_axil_rready !== 1'b0 || s_axil_arready !== 1'b0) bad = 1'b1;
            tick();
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL toaddr_hold: got arvalid/address dropped or rready/arready early want held");
        end
        m_axil_arready = 1'b1; tick(); m_axil_arready = 1'b0;
        vectors++;
        if ({m_axil_arvalid, m_axil_rready, busy} !== 3'b011) begin
            miscompares++;
            $display("FAIL toaddr_acc: got arvld/rrdy/busy=%b want 011", {m_axil_arvalid, m_axil_rready, busy});
        end
        tick(); tick();
        m_axil_rvalid = 1'b1; m_axil_rdata = 32'h1111_2222;
        tick();
        m_axil_rvalid = 1'b0;
        vectors++;
        if ({s_axil_arready, busy, s_axil_rvalid, timeout_count} !== {3'b100, exp_tcount}) begin
            miscompares++;
            $display("FAIL toaddr_done: got arrdy/busy/rvld=%b tcount=%0d want 100 %0d",
                     {s_axil_arready, busy, s_axil_rvalid}, timeout_count, exp_tcount);
        end
    endtask

    task automatic test_tie();
        accept_ar(32'h0000_4000, 3'b000);
        m_axil_arready = 1'b1; tick(); m_axil_arready = 1'b0;
        repeat (TO - 2) tick();
        vectors++;
        if ({m_axil_rready, s_axil_rvalid} !== 2'b10) begin
            miscompares++;
            $display("FAIL tie_pre: got rrdy/rvld=%b want 10", {m_axil_rready, s_axil_rvalid});
        end
        m_axil_rvalid = 1'b1; m_axil_rdata = 32'hA5A5_0001; m_axil_rresp = 2'b01;
        sb.push_back({32'hA5A5_0001, 2'b01});
        tick();
        m_axil_rvalid = 1'b0;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL tie_sb: got a response, scoreboard empty");
        end else begin
            e = sb.pop_front();
            if ({s_axil_rvalid, s_axil_rdata, s_axil_rresp, timeout_count} !== {1'b1, e.data, e.resp, exp_tcount}) begin
                miscompares++;
                $display("FAIL tie_data: got rvld=%b %h/%b cnt %0d want 1 %h/%b cnt %0d",
                         s_axil_rvalid, s_axil_rdata, s_axil_rresp, timeout_count, e.data, e.resp, exp_tcount);
            end
        end
        s_axil_rready = 1'b1; tick(); s_axil_rready = 1'b0;
        vectors++;
        if (s_axil_arready !== 1'b1) begin
            miscompares++;
            $display("FAIL tie_idle: got arready=%b want 1", s_axil_arready);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        bit bad;
        logic [31:0] d;
        d = $urandom;
        accept_ar(32'h0000_5000, 3'b000);
        m_axil_arready = 1'b1; tick(); m_axil_arready = 1'b0;
        tick(); tick();
        m_axil_rvalid = 1'b1; m_axil_rdata = d; m_axil_rresp = 2'b00;
        sb.push_back({d, 2'b00});
        tick();
        m_axil_rvalid = 1'b0;
        s_axil_araddr = 32'h0000_5555; s_axil_arvalid = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (s_axil_rvalid !== 1'b1 || s_axil_rdata !== d || s_axil_arready !== 1'b0 ||
                m_axil_arvalid !== 1'b0) bad = 1'b1;
        end
        s_axil_arvalid = 1'b0;
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL bp_resp_hold: got data unstable or AR accepted want stable %h", d);
        end
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL bp_resp_sb: got a response, scoreboard empty");
        end else begin
            e = sb.pop_front();
            if ({s_axil_rdata, s_axil_rresp} !== {e.data, e.resp}) begin
                miscompares++;
                $display("FAIL bp_resp_data: got %h/%b want %h/%b", s_axil_rdata, s_axil_rresp, e.data, e.resp);
            end
        end
        s_axil_rready = 1'b1; tick(); s_axil_rready = 1'b0;
        accept_ar(32'h0000_6000, 3'b000);
        m_axil_arready = 1'b1; tick(); m_axil_arready = 1'b0;
        sb.push_back({32'hDEADBEEF, 2'b10});
        exp_tcount = exp_tcount + 16'd1;
        wait_rvalid(40, cyc);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) begin
                if (m_axil_rready !== 1'b1) bad = 1'b1;
                m_axil_rvalid = 1'b1; m_axil_rdata = 32'h7777_7777;
            end
            tick();
            m_axil_rvalid = 1'b0;
            if (s_axil_rvalid !== 1'b1 || s_axil_rdata !== 32'hDEADBEEF || s_axil_rresp !== 2'b10) bad = 1'b1;
            if (i >= 2 && m_axil_rready !== 1'b0) bad = 1'b1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL bp_eresp_hold: got unstable error response or rready wrong want DEADBEEF/10");
        end
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL bp_eresp_sb: got a response, scoreboard empty");
        end else begin
            e = sb.pop_front();
            if ({s_axil_rdata, s_axil_rresp} !== {e.data, e.resp}) begin
                miscompares++;
                $display("FAIL bp_eresp_data: got %h/%b want %h/%b", s_axil_rdata, s_axil_rresp, e.data, e.resp);
            end
        end
        s_axil_rready = 1'b1; tick(); s_axil_rready = 1'b0;
        vectors++;
        if ({s_axil_arready, busy, s_axil_rvalid, timeout_count} !== {3'b100, exp_tcount}) begin
            miscompares++;
            $display("FAIL bp_eresp_exit: got arrdy/busy/rvld=%b tcount=%0d want 100 %0d",
                     {s_axil_arready, busy, s_axil_rvalid}, timeout_count, exp_tcount);
        end
    endtask

    task automatic test_async_reset();
        accept_ar(32'h0000_7000, 3'b011);
        m_axil_arready = 1'b1; tick(); m_axil_arready = 1'b0;
        tick(); tick();
        vectors++;
        if ({busy, m_axil_rready} !== 2'b11) begin
            miscompares++;
            $display("FAIL areset_pre: got busy/rrdy=%b want 11", {busy, m_axil_rready});
        end
        #2 s_rst = 1'b1;
        exp_tcount = 16'd0;
        #1;
        vectors++;
        if ({s_axil_arready, busy, m_axil_rready, m_axil_arvalid, s_axil_rvalid} !== 5'b10000 ||
            timeout_count !== exp_tcount || m_axil_araddr !== 32'd0 || s_axil_rdata !== 32'd0) begin
            miscompares++;
            $display("FAIL areset_out: got arrdy/busy/rrdy/arvld/rvld=%b tcount=%0d addr=%h want 10000 0 0",
                     {s_axil_arready, busy, m_axil_rready, m_axil_arvalid, s_axil_rvalid}, timeout_count, m_axil_araddr);
        end
        s_rst = 1'b0;
        tick(); tick();
        vectors++;
        if ({s_axil_arready, s_axil_rvalid} !== 2'b10) begin
            miscompares++;
            $display("FAIL areset_after: got arrdy/rvld=%b want 10", {s_axil_arready, s_axil_rvalid});
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            accept_ar(32'h0000_8000 + 32'(i * 4), 3'b000);
            m_axil_arready = 1'b1; tick(); m_axil_arready = 1'b0;
            m_axil_rvalid = 1'b1; m_axil_rdata = d; m_axil_rresp = 2'(i);
            sb.push_back({d, 2'(i)});
            tick();
            m_axil_rvalid = 1'b0;
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL b2b_sb: got a response, scoreboard empty");
            end else begin
                e = sb.pop_front();
                if ({s_axil_rvalid, s_axil_rdata, s_axil_rresp} !== {1'b1, e.data, e.resp}) begin
                    miscompares++;
                    $display("FAIL b2b_data[%0d]: got rvld=%b %h/%b want 1 %h/%b",
                             i, s_axil_rvalid, s_axil_rdata, s_axil_rresp, e.data, e.resp);
                end
            end
            s_axil_rready = 1'b1; tick(); s_axil_rready = 1'b0;
        end
        vectors++;
        if (sb.size() != 0 || timeout_count !== exp_tcount || s_axil_arready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_end: got sb=%0d tcount=%0d arready=%b want 0 %0d 1",
                     sb.size(), timeout_count, s_axil_arready, exp_tcount);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_normal();
        test_timeout_wait();
        test_timeout_addr();
        test_tie();
        test_backpressure();
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axil_rd_timeout.md
AXIL_RD_TIMEOUT -- requirements
Module: axil_rd_timeout

Placement: AXI-lite read-path stage on the s_clk side, directly upstream of the read CDC; guarantees the requester a response even if the far domain never answers.

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data bus width in bits.
REQ-002 Parameter ADDR_WIDTH, default 32, address bus width in bits.
REQ-003 Parameter TIMEOUT, default 1024, cycles from request acceptance to error response; legal range 2..65535.
REQ-004 Parameter ERR_DATA, default 32'hDEADBEEF, rdata returned on timeout, zero-extended or truncated to DATA_WIDTH.
REQ-005 s_clk  input  1  clock for all logic.
REQ-006 s_rst  input  1  reset, asynchronous, active-high.
REQ-007 s_axil_araddr / arprot / arvalid  input  ADDR_WIDTH / 3 / 1  upstream read address channel.
REQ-008 s_axil_arready  output  1  upstream address ready.
REQ-009 s_axil_rdata / rresp / rvalid  output  DATA_WIDTH / 2 / 1  upstream read response.
REQ-010 s_axil_rready  input  1  upstream response ready.
REQ-011 m_axil_araddr / arprot / arvalid  output  ADDR_WIDTH / 3 / 1  downstream read address (to CDC).
REQ-012 m_axil_arready  input  1  downstream address ready.
REQ-013 m_axil_rdata / rresp / rvalid  input  DATA_WIDTH / 2 / 1  downstream response.
REQ-014 m_axil_rready  output  1  downstream response ready.
REQ-015 timeout_count  output  16  saturating count of timeouts since reset.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 The block SHALL implement FSM states IDLE, ADDR, WAIT, RESP, ERESP, DRAIN and allow one outstanding transaction only.
REQ-018 s_axil_arready SHALL equal (state==IDLE), combinationally.
REQ-019 On upstream AR handshake, the block SHALL capture araddr/arprot into m_axil_araddr/arprot, assert m_axil_arvalid, clear the cycle counter, and enter ADDR; m_axil_arvalid is high the next cycle.
REQ-020 m_axil_arvalid SHALL remain high, with address stable, until the m_axil_arready handshake, in every state including ERESP and DRAIN; it is never withdrawn.
REQ-021 ADDR: on m_axil_arready, the block SHALL clear arvalid and go to WAIT.
REQ-022 m_axil_rready SHALL be high in WAIT, and in ERESP/DRAIN once arvalid has been accepted and the late response is still pending; low otherwise.
REQ-023 WAIT: on m_axil_rvalid, the block SHALL register rdata/rresp into s_axil_rdata/rresp, assert s_axil_rvalid, and enter RESP.
REQ-024 RESP: s_axil_rvalid SHALL be held with stable data until s_axil_rready, then return to IDLE.
REQ-025 The counter SHALL increment each cycle in ADDR and WAIT.
REQ-026 The cycle the counter equals TIMEOUT-1 without a response arriving, the block SHALL:
- enter ERESP;
- drive s_axil_rvalid=1, rdata=ERR_DATA, rresp=2'b10 (SLVERR) next cycle;
- increment timeout_count, saturating at 16'hFFFF.
REQ-027 A downstream response arriving in the same cycle as timeout expiry SHALL win: normal RESP path, no error, no count increment.
REQ-028 In ERESP and DRAIN, a downstream R handshake SHALL be discarded and set an internal late_done flag, never forwarded upstream.
REQ-029 ERESP: on s_axil_rready, the block SHALL go to IDLE if late_done, else to DRAIN.
REQ-030 DRAIN: the block SHALL keep s_axil_arready low; on the downstream R handshake it SHALL go to IDLE.
REQ-031 The cycle counter SHALL be wide enough for TIMEOUT-1, with no wrap before expiry.

Reset
REQ-032 On s_rst, the block SHALL go to IDLE and clear:
- m_axil_arvalid, s_axil_rvalid;
- all data/addr/resp registers;
- counter, late_done, timeout_count.
REQ-033 Outputs in reset SHALL be s_axil_arready=1, m_axil_rready=0, busy=0.
REQ-034 Reset mid-transaction SHALL abandon the transaction with no response issued; resetting the downstream side is the integrator's responsibility.

Verification
REQ-035 Normal read: AR 0x0000_1000, downstream arready at +2, rvalid with 0x1234_5678/OKAY at +5 -> upstream rdata 0x1234_5678, rresp 0, timeout_count 0.
REQ-036 Timeout in WAIT (TIMEOUT=16): no downstream response -> s_axil_rvalid with 0xDEADBEEF/SLVERR 16 cycles after acceptance; response late at +40 is dropped; arready returns only after it; timeout_count=1.
REQ-037 Timeout in ADDR: arready withheld 30 cycles (TIMEOUT=16) -> error response issued; m_axil_arvalid stays high until accepted; subsequent rvalid drained; then IDLE.
REQ-038 Tie: rvalid in the exact expiry cycle -> real data forwarded, timeout_count unchanged.
REQ-039 Backpressure: s_axil_rready low 10 cycles in RESP and in ERESP -> data stable, no new AR accepted; late response during ERESP sets late_done, so ERESP exits straight to IDLE.
REQ-040 Async reset asserted in WAIT -> all outputs at reset values within the same cycle, busy=0.
